// File: rtl/dcache_mem_pkg.sv
// rtl/dcache_mem_pkg.sv - shared types and sizes for the two-way data cache arrays
package dcache_mem_pkg;

    localparam int INDEX_BITS  = 4;
    localparam int TAG_BITS    = 25;
    localparam int DCACHE_WAYS = 2;
    localparam int NUM_SETS    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        COMMAND_NONE  = 2'd0,
        COMMAND_LOAD  = 2'd1,
        COMMAND_STORE = 2'd2
    } CACHE_COMMAND;

endpackage

// File: rtl/dcache_way_select.sv
// rtl/dcache_way_select.sv - per-set way choice for a store and a fill landing in one cycle
module dcache_way_select
    import dcache_mem_pkg::*;
(
    input  logic [DCACHE_WAYS-1:0]               valid,
    input  logic [DCACHE_WAYS-1:0][TAG_BITS-1:0] tags,
    input  logic                                 lru,
    input  logic                                 collide,
    input  logic [TAG_BITS-1:0]                  store_tag,
    input  logic [TAG_BITS-1:0]                  fill_tag,
    output logic                                 hit,
    output logic                                 hit_way,
    output logic                                 store_way,
    output logic                                 fill_way,
    output logic                                 fill_drop
);

    logic [DCACHE_WAYS-1:0] store_match;
    logic [DCACHE_WAYS-1:0] fill_match;

    // Store reuses its resident way or takes the victim; a same-set fill takes the way the store leaves alone
    always_comb begin
        for (int w = 0; w < DCACHE_WAYS; w++) begin
            store_match[w] = valid[w] && (tags[w] == store_tag);
            fill_match[w]  = valid[w] && (tags[w] == fill_tag);
        end
        hit       = |store_match;
        hit_way   = store_match[1];
        store_way = hit ? hit_way : lru;
        // A resident copy is at least as new as the memory response, so the fill is dropped
        fill_drop = |fill_match;
        fill_way  = lru;
        if (collide) begin
            fill_drop = (|fill_match) || (fill_tag == store_tag);
            fill_way  = ~store_way;
        end
    end

endmodule

// File: rtl/dcache_mem.sv
// rtl/dcache_mem.sv - two-way set-associative data/tag array with one read port, store and fill writes
module dcache_mem
    import dcache_mem_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd1_idx,
    input  logic [TAG_BITS-1:0]   rd1_tag,
    input  CACHE_COMMAND          proc2Dcache_command_1,
    input  logic                  wr1_req_en,
    input  logic [INDEX_BITS-1:0] wr1_req_idx,
    input  logic [TAG_BITS-1:0]   wr1_req_tag,
    input  logic [63:0]           wr1_req_data,
    input  logic                  wr1_missed_load_en,
    input  logic [INDEX_BITS-1:0] wr1_missed_load_idx,
    input  logic [TAG_BITS-1:0]   wr1_missed_load_tag,
    input  logic [63:0]           Dmem2proc_data,
    output logic [63:0]           Dcache_data_1,
    output logic                  Dcache_valid_1
);

    logic [NUM_SETS-1:0][DCACHE_WAYS-1:0]               valid_q, valid_d;
    logic [NUM_SETS-1:0][DCACHE_WAYS-1:0][TAG_BITS-1:0] tag_q, tag_d;
    logic [NUM_SETS-1:0][DCACHE_WAYS-1:0][63:0]         data_q, data_d;
    logic [NUM_SETS-1:0]                                lru_q, lru_d;

    logic [NUM_SETS-1:0] st_sel, fl_sel;
    logic [NUM_SETS-1:0] st_hit, st_hit_way, st_way, fl_way, fl_drop;
    logic [DCACHE_WAYS-1:0] rd_match;
    logic                   rd_hit;
    logic                   rd_way;

    // Decode which set the store and the fill target this cycle
    always_comb begin
        for (int s = 0; s < NUM_SETS; s++) begin
            st_sel[s] = wr1_req_en && (wr1_req_idx == INDEX_BITS'(s));
            fl_sel[s] = wr1_missed_load_en && (wr1_missed_load_idx == INDEX_BITS'(s));
        end
    end

    for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
        dcache_way_select u_way_select (
            .valid     (valid_q[s]),
            .tags      (tag_q[s]),
            .lru       (lru_q[s]),
            .collide   (st_sel[s] && fl_sel[s]),
            .store_tag (wr1_req_tag),
            .fill_tag  (wr1_missed_load_tag),
            .hit       (st_hit[s]),
            .hit_way   (st_hit_way[s]),
            .store_way (st_way[s]),
            .fill_way  (fl_way[s]),
            .fill_drop (fl_drop[s])
        );
    end

    // Zero-latency lookup over registered state only; same-cycle writes are not forwarded
    always_comb begin
        for (int w = 0; w < DCACHE_WAYS; w++) begin
            rd_match[w] = valid_q[rd1_idx][w] && (tag_q[rd1_idx][w] == rd1_tag);
        end
        rd_hit         = |rd_match;
        rd_way         = rd_match[1];
        Dcache_valid_1 = rd_hit;
        Dcache_data_1  = rd_hit ? data_q[rd1_idx][rd_way] : 64'd0;
    end

    // Next array state; later assignments win, giving LRU priority store > fill > load hit
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        lru_d   = lru_q;
        if ((proc2Dcache_command_1 == COMMAND_LOAD) && rd_hit) begin
            lru_d[rd1_idx] = ~rd_way;
        end
        for (int s = 0; s < NUM_SETS; s++) begin
            if (fl_sel[s] && !fl_drop[s]) begin
                valid_d[s][fl_way[s]] = 1'b1;
                tag_d[s][fl_way[s]]   = wr1_missed_load_tag;
                data_d[s][fl_way[s]]  = Dmem2proc_data;
                lru_d[s]              = ~fl_way[s];
            end
            if (st_sel[s]) begin
                // A resident store hit only needs the data refreshed; valid/tag rewrite is harmless
                valid_d[s][st_way[s]] = 1'b1;
                tag_d[s][st_way[s]]   = st_hit[s] ? tag_q[s][st_hit_way[s]] : wr1_req_tag;
                data_d[s][st_way[s]]  = wr1_req_data;
                lru_d[s]              = ~st_way[s];
            end
        end
    end

    // Valid and LRU state clear asynchronously so lookups miss as soon as reset rises
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            lru_q   <= '0;
        end else begin
            valid_q <= valid_d;
            lru_q   <= lru_d;
        end
    end

    // Tag and data payload need no reset; they are masked by the valid bits
    always_ff @(posedge clock) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_dcache_mem.sv
// tb/tb_dcache_mem.sv - self-checking bench for dcache_mem against a behavioural cache model
module tb_dcache_mem;
    import dcache_mem_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   rd1_idx;
    logic [24:0]  rd1_tag;
    CACHE_COMMAND cmd;
    logic         wr1_req_en;
    logic [3:0]   wr1_req_idx;
    logic [24:0]  wr1_req_tag;
    logic [63:0]  wr1_req_data;
    logic         wr1_missed_load_en;
    logic [3:0]   wr1_missed_load_idx;
    logic [24:0]  wr1_missed_load_tag;
    logic [63:0]  Dmem2proc_data;
    logic [63:0]  Dcache_data_1;
    logic         Dcache_valid_1;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: per set, two slots and a victim pointer
    bit          mv [16][2];
    logic [24:0] mt [16][2];
    logic [63:0] md [16][2];
    bit          ml [16];

    always #5 clock = ~clock;

    dcache_mem dut (
        .clock                 (clock),
        .reset                 (reset),
        .rd1_idx               (rd1_idx),
        .rd1_tag               (rd1_tag),
        .proc2Dcache_command_1 (cmd),
        .wr1_req_en            (wr1_req_en),
        .wr1_req_idx           (wr1_req_idx),
        .wr1_req_tag           (wr1_req_tag),
        .wr1_req_data          (wr1_req_data),
        .wr1_missed_load_en    (wr1_missed_load_en),
        .wr1_missed_load_idx   (wr1_missed_load_idx),
        .wr1_missed_load_tag   (wr1_missed_load_tag),
        .Dmem2proc_data        (Dmem2proc_data),
        .Dcache_data_1         (Dcache_data_1),
        .Dcache_valid_1        (Dcache_valid_1)
    );

    function automatic int find_way(int idx, logic [24:0] tag);
        for (int w = 0; w < 2; w++) if (mv[idx][w] && mt[idx][w] == tag) return w;
        return -1;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            ml[s] = 0;
            for (int w = 0; w < 2; w++) mv[s][w] = 0;
        end
    endtask

    task automatic model_commit();
        int  rw, sw, fw, fi, si;
        bit  fdrop;
        fi = wr1_missed_load_idx;
        si = wr1_req_idx;
        rw = find_way(rd1_idx, rd1_tag);
        sw = 0;
        if (wr1_req_en) begin
            sw = find_way(si, wr1_req_tag);
            if (sw < 0) sw = ml[si];
        end
        fdrop = 1;
        fw    = 0;
        if (wr1_missed_load_en) begin
            fdrop = (find_way(fi, wr1_missed_load_tag) >= 0);
            if (wr1_req_en && si == fi) begin
                if (wr1_req_tag == wr1_missed_load_tag) fdrop = 1;
                fw = 1 - sw;
            end else begin
                fw = ml[fi];
            end
        end
        if (cmd == COMMAND_LOAD && rw >= 0) ml[rd1_idx] = (rw == 0);
        if (wr1_missed_load_en && !fdrop) begin
            mv[fi][fw] = 1;
            mt[fi][fw] = wr1_missed_load_tag;
            md[fi][fw] = Dmem2proc_data;
            ml[fi]     = (fw == 0);
        end
        if (wr1_req_en) begin
            mv[si][sw] = 1;
            mt[si][sw] = wr1_req_tag;
            md[si][sw] = wr1_req_data;
            ml[si]     = (sw == 0);
        end
    endtask

    task automatic idle_inputs();
        cmd                 = COMMAND_NONE;
        wr1_req_en          = 1'b0;
        wr1_req_idx         = '0;
        wr1_req_tag         = '0;
        wr1_req_data        = '0;
        wr1_missed_load_en  = 1'b0;
        wr1_missed_load_idx = '0;
        wr1_missed_load_tag = '0;
        Dmem2proc_data      = '0;
    endtask

    task automatic cycle();
        @(posedge clock);
        if (!reset) model_commit();
    endtask

    task automatic do_fill(input logic [3:0] idx, input logic [24:0] tag, input logic [63:0] data);
        @(negedge clock);
        idle_inputs();
        wr1_missed_load_en  = 1'b1;
        wr1_missed_load_idx = idx;
        wr1_missed_load_tag = tag;
        Dmem2proc_data      = data;
        cycle();
    endtask

    task automatic do_store(input logic [3:0] idx, input logic [24:0] tag, input logic [63:0] data);
        @(negedge clock);
        idle_inputs();
        wr1_req_en   = 1'b1;
        wr1_req_idx  = idx;
        wr1_req_tag  = tag;
        wr1_req_data = data;
        cycle();
    endtask

    task automatic do_load(input logic [3:0] idx, input logic [24:0] tag);
        @(negedge clock);
        idle_inputs();
        cmd     = COMMAND_LOAD;
        rd1_idx = idx;
        rd1_tag = tag;
        cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        rd1_idx = 4'd3;
        rd1_tag = 25'h10;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++;
        if (Dcache_valid_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %0b expected 0", Dcache_valid_1);
        end
        n_checks++;
        if (Dcache_data_1 !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %0h expected 0", Dcache_data_1);
        end
    endtask

    task automatic test_fill_hit();
        @(negedge clock);
        idle_inputs();
        wr1_missed_load_en  = 1'b1;
        wr1_missed_load_idx = 4'd3;
        wr1_missed_load_tag = 25'h10;
        Dmem2proc_data      = 64'hAAAA;
        rd1_idx = 4'd3;
        rd1_tag = 25'h10;
        #1;
        n_checks++;
        if (Dcache_valid_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL no_forwarding: got valid %0b expected 0", Dcache_valid_1);
        end
        cycle();
        @(negedge clock);
        idle_inputs();
        cmd = COMMAND_LOAD;
        #1;
        n_checks++;
        if (Dcache_valid_1 !== 1'b1 || Dcache_data_1 !== 64'hAAAA) begin
            n_fail++;
            $display("FAIL fill_hit: got valid %0b data %0h expected 1 aaaa", Dcache_valid_1, Dcache_data_1);
        end
        cycle();
        #1;
        n_checks++;
        if (dut.lru_q[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_hit_lru: got %0b expected 1", dut.lru_q[3]);
        end
    endtask

    task automatic test_lru_evict();
        do_fill(4'd5, 25'h1, 64'h101);
        do_fill(4'd5, 25'h2, 64'h202);
        do_load(4'd5, 25'h1);
        do_fill(4'd5, 25'h3, 64'h303);
        @(negedge clock);
        idle_inputs();
        rd1_idx = 4'd5;
        rd1_tag = 25'h2;
        #1;
        n_checks++;
        if (Dcache_valid_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL lru_evicted: got valid %0b expected 0", Dcache_valid_1);
        end
        rd1_tag = 25'h1;
        #1;
        n_checks++;
        if (Dcache_valid_1 !== 1'b1 || Dcache_data_1 !== 64'h101) begin
            n_fail++;
            $display("FAIL lru_kept: got valid %0b data %0h expected 1 101", Dcache_valid_1, Dcache_data_1);
        end
        rd1_tag = 25'h3;
        #1;
        n_checks++;
        if (Dcache_valid_1 !== 1'b1 || Dcache_data_1 !== 64'h303) begin
            n_fail++;
            $display("FAIL lru_newfill: got valid %0b data %0h expected 1 303", Dcache_valid_1, Dcache_data_1);
        end
    endtask

    task automatic test_collision();
        @(negedge clock);
        idle_inputs();
        wr1_req_en          = 1'b1;
        wr1_req_idx         = 4'd7;
        wr1_req_tag         = 25'h4;
        wr1_req_data        = 64'h1111;
        wr1_missed_load_en  = 1'b1;
        wr1_missed_load_idx = 4'd7;
        wr1_missed_load_tag = 25'h4;
        Dmem2proc_data      = 64'h2222;
        cycle();
        @(negedge clock);
        idle_inputs();
        rd1_idx = 4'd7;
        rd1_tag = 25'h4;
        #1;
        n_checks++;
        if (Dcache_valid_1 !== 1'b1 || Dcache_data_1 !== 64'h1111) begin
            n_fail++;
            $display("FAIL collision_same: got valid %0b data %0h expected 1 1111", Dcache_valid_1, Dcache_data_1);
        end
    endtask

    task automatic test_stale_fill();
        do_fill(4'd2, 25'hA, 64'h77);
        do_store(4'd2, 25'h9, 64'h55);
        do_fill(4'd2, 25'h9, 64'h66);
        @(negedge clock);
        idle_inputs();
        rd1_idx = 4'd2;
        rd1_tag = 25'h9;
        #1;
        n_checks++;
        if (Dcache_valid_1 !== 1'b1 || Dcache_data_1 !== 64'h55) begin
            n_fail++;
            $display("FAIL stale_fill: got valid %0b data %0h expected 1 55", Dcache_valid_1, Dcache_data_1);
        end
        rd1_tag = 25'hA;
        #1;
        n_checks++;
        if (Dcache_valid_1 !== 1'b1 || Dcache_data_1 !== 64'h77) begin
            n_fail++;
            $display("FAIL stale_other_way: got valid %0b data %0h expected 1 77", Dcache_valid_1, Dcache_data_1);
        end
    endtask

    task automatic test_async_reset();
        logic [3:0]  idx_tab [4];
        logic [24:0] tag_tab [4];
        idx_tab = '{4'd3, 4'd9, 4'd5, 4'd2};
        tag_tab = '{25'h10, 25'h5, 25'h1, 25'h9};
        @(negedge clock);
        idle_inputs();
        wr1_missed_load_en  = 1'b1;
        wr1_missed_load_idx = 4'd9;
        wr1_missed_load_tag = 25'h5;
        Dmem2proc_data      = 64'h999;
        rd1_idx = 4'd3;
        rd1_tag = 25'h10;
        #1;
        n_checks++;
        if (Dcache_valid_1 !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_hit: got %0b expected 1", Dcache_valid_1);
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (Dcache_valid_1 !== 1'b0 || Dcache_data_1 !== 64'd0) begin
            n_fail++;
            $display("FAIL async_reset: got valid %0b data %0h expected 0 0", Dcache_valid_1, Dcache_data_1);
        end
        @(posedge clock);
        #2 reset = 1'b0;
        model_reset();
        @(negedge clock);
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            rd1_idx = idx_tab[i];
            rd1_tag = tag_tab[i];
            #1;
            n_checks++;
            if (Dcache_valid_1 !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_miss[%0d]: got valid %0b expected 0", i, Dcache_valid_1);
            end
        end
    endtask

    task automatic test_random();
        int  w;
        bit  exp_valid;
        logic [63:0] exp_data;
        for (int n = 0; n < 600; n++) begin
            @(negedge clock);
            cmd                 = CACHE_COMMAND'($urandom_range(0, 2));
            wr1_req_en          = ($urandom_range(0, 2) == 0);
            wr1_req_idx         = 4'($urandom_range(0, 3));
            wr1_req_tag         = 25'($urandom_range(0, 3));
            wr1_req_data        = {$urandom, $urandom};
            wr1_missed_load_en  = ($urandom_range(0, 2) == 0);
            wr1_missed_load_idx = 4'($urandom_range(0, 3));
            wr1_missed_load_tag = 25'($urandom_range(0, 3));
            Dmem2proc_data      = {$urandom, $urandom};
            rd1_idx             = 4'($urandom_range(0, 3));
            rd1_tag             = 25'($urandom_range(0, 3));
            #1;
            w         = find_way(rd1_idx, rd1_tag);
            exp_valid = (w >= 0);
            exp_data  = (w >= 0) ? md[rd1_idx][w] : 64'd0;
            n_checks++;
            if (Dcache_valid_1 !== exp_valid || Dcache_data_1 !== exp_data) begin
                n_fail++;
                $display("FAIL random_lookup[%0d]: got valid %0b data %0h expected %0b %0h",
                         n, Dcache_valid_1, Dcache_data_1, exp_valid, exp_data);
            end
            n_checks++;
            if (dut.lru_q[rd1_idx] !== ml[rd1_idx]) begin
                n_fail++;
                $display("FAIL random_lru[%0d]: set %0d got %0b expected %0b",
                         n, rd1_idx, dut.lru_q[rd1_idx], ml[rd1_idx]);
            end
            cycle();
        end
    endtask

    initial begin
        test_reset();
        test_fill_hit();
        test_lru_evict();
        test_collision();
        test_stale_fill();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
